// File: rtl/ntt_ctrl_pkg.sv
// Shared constants and types for the Kyber NTT butterfly-stage controller.
package ntt_ctrl_pkg;

    localparam int N      = 256;
    localparam int LAYERS = 7;
    localparam int AW     = 8;
    localparam int TWW    = 7;

    localparam logic MODE_NTT  = 1'b1;
    localparam logic MODE_INTT = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/ntt_ctrl_if.sv
// Control and coefficient-RAM sequencing bundle between ntt_ctrl (master) and the datapath (slave).
interface ntt_ctrl_if #(
    parameter int AW  = ntt_ctrl_pkg::AW,
    parameter int TWW = ntt_ctrl_pkg::TWW
);
    logic           start;
    logic           mode;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic [AW-1:0]  rd_addr0;
    logic [AW-1:0]  rd_addr1;
    logic [TWW-1:0] tw_idx;
    logic [1:0]     bf_sel;
    logic           wr_en;
    logic [AW-1:0]  wr_addr0;
    logic [AW-1:0]  wr_addr1;

    modport master (
        input  start, mode,
        output busy, done, rd_en, rd_addr0, rd_addr1, tw_idx, bf_sel,
               wr_en, wr_addr0, wr_addr1
    );

    modport slave (
        output start, mode,
        input  busy, done, rd_en, rd_addr0, rd_addr1, tw_idx, bf_sel,
               wr_en, wr_addr0, wr_addr1
    );
endinterface

// File: rtl/dly_chain.sv
// Fixed-depth flop chain: q is d delayed by K clock cycles (K = 0 degenerates to a wire).
module dly_chain #(
    parameter int W = 1,
    parameter int K = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (K == 0) begin : g_wire
        assign q = d;
    end else begin : g_chain
        logic [K-1:0][W-1:0] stage_q, stage_d;

        always_comb begin
            stage_d[0] = d;
            for (int i = 1; i < K; i++) stage_d[i] = stage_q[i-1];
        end

        // NOTE: every stage is reset, so a reset cannot leave stale write strobes in flight.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) stage_q <= '0;
            else     stage_q <= stage_d;
        end

        assign q = stage_q[K-1];
    end
endmodule

// File: rtl/ntt_addr_calc.sv
// Maps (layer, butterfly, mode) to the coefficient pair addresses and twiddle index.
module ntt_addr_calc #(
    parameter int AW  = ntt_ctrl_pkg::AW,
    parameter int TWW = ntt_ctrl_pkg::TWW
) (
    input  logic [2:0]     l,
    input  logic [AW-2:0]  b,
    input  logic           mode,
    output logic [AW-1:0]  addr0,
    output logic [AW-1:0]  addr1,
    output logic [TWW-1:0] tw_idx
);
    import ntt_ctrl_pkg::*;

    logic [2:0]    lg;
    logic [AW-2:0] grp, j;
    logic [AW-1:0] len;

    // lg = log2(len): CT halves the span each layer, GS doubles it.
    always_comb begin
        lg     = (mode == MODE_NTT) ? 3'(AW - 1) - l : l + 3'd1;
        len    = AW'(1) << lg;
        grp    = b >> lg;
        j      = b & ~({(AW-1){1'b1}} << lg);
        addr0  = (({1'b0, grp} << lg) << 1) | {1'b0, j};
        addr1  = addr0 + len;
        tw_idx = (mode == MODE_NTT) ? (TWW'(1) << l) + TWW'(grp)
                                    : ({TWW{1'b1}} >> l) - TWW'(grp);
    end
endmodule

// File: rtl/ntt_ctrl.sv
// Butterfly-stage sequencer for the Kyber NTT: issues one read pair per cycle over 7 layers
// and replays each read as a write-back once the RAM and butterfly pipeline have drained.
module ntt_ctrl #(
    parameter int RDLAT = 1,
    parameter int BFLAT = 11,
    parameter int AW    = ntt_ctrl_pkg::AW,
    parameter int TWW   = ntt_ctrl_pkg::TWW
) (
    input  logic      clk,
    input  logic      rst,
    ntt_ctrl_if.master bus
);
    import ntt_ctrl_pkg::*;

    localparam int L  = RDLAT + BFLAT;
    localparam int DW = $clog2(L + 1);
    localparam int BW = AW - 1;

    state_e         state_q, state_d;
    logic [2:0]     l_q, l_d;
    logic [BW-1:0]  b_q, b_d;
    logic [DW-1:0]  dcnt_q, dcnt_d;
    logic           mode_q, mode_d;
    logic           run;
    logic [AW-1:0]  calc_addr0, calc_addr1;
    logic [TWW-1:0] calc_tw;
    logic [2*AW:0]  wr_bundle;

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            l_q     <= '0;
            b_q     <= '0;
            dcnt_q  <= '0;
            mode_q  <= MODE_INTT;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            b_q     <= b_d;
            dcnt_q  <= dcnt_d;
            mode_q  <= mode_d;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        b_d     = b_q;
        dcnt_d  = dcnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                mode_d  = bus.mode;
                l_d     = '0;
                b_d     = '0;
            end
            RUN: begin
                b_d    = b_q + BW'(1);
                dcnt_d = '0;
                if (b_q == BW'(N / 2 - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                dcnt_d = dcnt_q + DW'(1);
                if (dcnt_q == DW'(L - 1)) begin
                    if (l_q == 3'(LAYERS - 1)) begin
                        state_d = DONE;
                    end else begin
                        l_d     = l_q + 3'd1;
                        b_d     = '0;
                        state_d = RUN;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    ntt_addr_calc #(.AW(AW), .TWW(TWW)) u_addr (
        .l      (l_q),
        .b      (b_q),
        .mode   (mode_q),
        .addr0  (calc_addr0),
        .addr1  (calc_addr1),
        .tw_idx (calc_tw)
    );

    // Address and index outputs are held at zero outside RUN.
    always_comb begin
        run          = (state_q == RUN);
        bus.busy     = (state_q == RUN) || (state_q == DRAIN);
        bus.done     = (state_q == DONE);
        bus.rd_en    = run;
        bus.rd_addr0 = run ? calc_addr0 : '0;
        bus.rd_addr1 = run ? calc_addr1 : '0;
        bus.tw_idx   = run ? calc_tw    : '0;
    end

    dly_chain #(.W(2), .K(RDLAT)) u_sel_dly (
        .clk (clk),
        .rst (rst),
        .d   ({1'b0, mode_q}),
        .q   (bus.bf_sel)
    );

    dly_chain #(.W(2 * AW + 1), .K(L)) u_wr_dly (
        .clk (clk),
        .rst (rst),
        .d   ({bus.rd_en, bus.rd_addr0, bus.rd_addr1}),
        .q   (wr_bundle)
    );

    assign bus.wr_en    = wr_bundle[2*AW];
    assign bus.wr_addr0 = wr_bundle[2*AW-1:AW];
    assign bus.wr_addr1 = wr_bundle[AW-1:0];
endmodule

// File: tb/tb_ntt_ctrl.sv
// Self-checking bench for ntt_ctrl: full transforms against an arithmetic reference model,
// a table of known address/twiddle points, randomized start/mode noise and a mid-run reset.
module tb_ntt_ctrl;
    import ntt_ctrl_pkg::*;

    localparam int RDLAT = 1;
    localparam int BFLAT = 11;
    localparam int L     = RDLAT + BFLAT;
    localparam int LAYER_CYC = 128 + L;

    typedef struct {
        int cyc;
        int a0;
        int a1;
        int tw;
    } ev_t;

    typedef struct {
        logic m;
        int   l;
        int   b;
        int   a0;
        int   a1;
        int   tw;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    ev_t  rd_q[$];
    ev_t  wr_q[$];
    int   rec_a0 [2][7][128];
    int   rec_a1 [2][7][128];
    int   rec_tw [2][7][128];
    vec_t tbl [6];

    always #5 clk = ~clk;

    ntt_ctrl_if #(.AW(AW), .TWW(TWW)) bus ();

    ntt_ctrl #(.RDLAT(RDLAT), .BFLAT(BFLAT), .AW(AW), .TWW(TWW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference: len, group and offset straight from the transform definition.
    function automatic void model(input logic m, input int l, input int b,
                                  output int a0, output int a1, output int tw);
        int len, grp, j;
        len = m ? (128 >> l) : (2 << l);
        grp = b / len;
        j   = b % len;
        a0  = grp * 2 * len + j;
        a1  = a0 + len;
        tw  = m ? (1 << l) + grp : (128 >> l) - 1 - grp;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  bus.busy,     0);
        check({tag, "_done"},  bus.done,     0);
        check({tag, "_rd_en"}, bus.rd_en,    0);
        check({tag, "_rd0"},   bus.rd_addr0, 0);
        check({tag, "_rd1"},   bus.rd_addr1, 0);
        check({tag, "_tw"},    bus.tw_idx,   0);
        check({tag, "_sel"},   bus.bf_sel,   0);
        check({tag, "_wr_en"}, bus.wr_en,    0);
        check({tag, "_wr0"},   bus.wr_addr0, 0);
        check({tag, "_wr1"},   bus.wr_addr1, 0);
    endtask

    // One transform from an IDLE controller; optional noise on start and mode while busy.
    task automatic run_xform(input logic m, input bit chaos);
        int done_n, done_cnt, nbad, l, b, a0, a1, tw;
        int hits [256];
        rd_q.delete();
        wr_q.delete();
        done_n   = -1;
        done_cnt = 0;
        bus.start = 1'b1;
        bus.mode  = m;
        for (int n = 1; n <= 1100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.rd_en)
                rd_q.push_back('{n, int'(bus.rd_addr0), int'(bus.rd_addr1), int'(bus.tw_idx)});
            if (bus.wr_en)
                wr_q.push_back('{n, int'(bus.wr_addr0), int'(bus.wr_addr1), 0});
            if (n >= 1 + RDLAT && done_n < 0) check("bf_sel", bus.bf_sel, {1'b0, m});
            if (n <= 7 * LAYER_CYC) check("busy", bus.busy, 1);
            if (bus.done) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
            end
            if (done_n > 0 && n >= done_n + 3) break;
            bus.start = chaos && (done_n < 0) && ($urandom_range(0, 15) == 0);
            bus.mode  = chaos ? 1'($urandom_range(0, 1)) : m;
        end
        bus.start = 1'b0;

        check("start_to_done", done_n, 7 * LAYER_CYC + 1);
        check("done_pulses", done_cnt, 1);
        check("rd_count", rd_q.size(), 896);
        check("wr_count", wr_q.size(), 896);

        for (int k = 0; k < rd_q.size() && k < 896; k++) begin
            l = k / 128;
            b = k % 128;
            model(m, l, b, a0, a1, tw);
            check("rd_cyc",   rd_q[k].cyc, 1 + l * LAYER_CYC + b);
            check("rd_addr0", rd_q[k].a0, a0);
            check("rd_addr1", rd_q[k].a1, a1);
            check("tw_idx",   rd_q[k].tw, tw);
            rec_a0[int'(m)][l][b] = rd_q[k].a0;
            rec_a1[int'(m)][l][b] = rd_q[k].a1;
            rec_tw[int'(m)][l][b] = rd_q[k].tw;
        end
        for (int k = 0; k < wr_q.size() && k < 896; k++) begin
            l = k / 128;
            b = k % 128;
            model(m, l, b, a0, a1, tw);
            check("wr_cyc",   wr_q[k].cyc, 1 + l * LAYER_CYC + b + L);
            check("wr_addr0", wr_q[k].a0, a0);
            check("wr_addr1", wr_q[k].a1, a1);
        end

        if (rd_q.size() == 896 && wr_q.size() == 896) begin
            for (int lay = 0; lay < 7; lay++) begin
                foreach (hits[i]) hits[i] = 0;
                for (int k = lay * 128; k < lay * 128 + 128; k++) begin
                    hits[rd_q[k].a0 & 255]++;
                    hits[rd_q[k].a1 & 255]++;
                end
                nbad = 0;
                foreach (hits[i]) if (hits[i] != 1) nbad++;
                check("layer_cover", nbad, 0);
                if (lay > 0)
                    check("no_rd_before_wr", rd_q[lay * 128].cyc > wr_q[lay * 128 - 1].cyc, 1);
            end
        end
    endtask

    task automatic reset_mid_run();
        bus.mode  = MODE_NTT;
        bus.start = 1'b1;
        for (int n = 1; n <= 1 + 3 * LAYER_CYC + 50; n++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            bus.mode  = 1'($urandom_range(0, 1));
        end
        check("pre_rst_rd_en", bus.rd_en, 1);
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("post_rst_wr_en", bus.wr_en, 0);
            check("post_rst_rd_en", bus.rd_en, 0);
            check("post_rst_busy",  bus.busy,  0);
        end
    endtask

    initial begin
        tbl[0] = '{MODE_NTT,  0,   0,   0, 128,   1};
        tbl[1] = '{MODE_NTT,  0, 127, 127, 255,   1};
        tbl[2] = '{MODE_NTT,  1,  64, 128, 192,   3};
        tbl[3] = '{MODE_INTT, 0,   0,   0,   2, 127};
        tbl[4] = '{MODE_INTT, 0,   2,   4,   6, 126};
        tbl[5] = '{MODE_INTT, 6,   0,   0, 128,   1};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("idle");

        run_xform(MODE_NTT, 1'b0);
        run_xform(MODE_INTT, 1'b0);

        for (int i = 0; i < 6; i++) begin
            check("tbl_addr0", rec_a0[int'(tbl[i].m)][tbl[i].l][tbl[i].b], tbl[i].a0);
            check("tbl_addr1", rec_a1[int'(tbl[i].m)][tbl[i].l][tbl[i].b], tbl[i].a1);
            check("tbl_tw",    rec_tw[int'(tbl[i].m)][tbl[i].l][tbl[i].b], tbl[i].tw);
        end

        for (int r = 0; r < 2; r++) begin
            repeat ($urandom_range(1, 6)) @(negedge clk);
            run_xform(1'($urandom_range(0, 1)), 1'b1);
        end

        reset_mid_run();
        run_xform(MODE_NTT, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencing controller for the butterfly stage of the Kyber NTT datapath. It issues dual read addresses to the 256×12-bit coefficient RAM, supplies the twiddle-ROM index and the butterfly mode select in step with the RAM read data, and produces matching write-back addresses and enables timed to the butterfly pipeline output. It covers all 7 layers of a forward (CT) or inverse (GS) transform at one butterfly per cycle, draining the pipeline between layers. Final INTT scaling is not part of this block.

## Interface
Parameters:
- RDLAT, 1, coefficient RAM read latency (cycles from address to data)
- BFLAT, 11, butterfly latency (cycles from inputs to s0/s1)
- AW, 8, coefficient address width
- TWW, 7, twiddle index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  1 = NTT (CT), 0 = INTT (GS); latched on accepted start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of transform
- rd_en  out  1  coefficient read strobe
- rd_addr0, rd_addr1  out  AW  pair addresses (j, j+len)
- tw_idx  out  TWW  twiddle ROM index, aligned with rd_addr
- bf_sel  out  2  {bypass, mode}, delayed RDLAT to align with RAM data; bypass is always 0
- wr_en  out  1  coefficient write strobe
- wr_addr0, wr_addr1  out  AW  write-back addresses for s0/s1

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start; latch mode, clear the layer counter l and the butterfly counter b.
  - RUN issues one butterfly per cycle, b = 0..127. When b = 127, go to DRAIN.
  - DRAIN counts L = RDLAT+BFLAT cycles. At the end: if l < 6, increment l, clear b, go to RUN; otherwise go to DONE.
  - DONE lasts one cycle, asserts done, then returns to IDLE.
- Addressing:
  - NTT: len = 128>>l. INTT: len = 2<<l.
  - group = b/len, j = b mod len (shift/mask only).
  - rd_addr0 = group·2·len + j; rd_addr1 = rd_addr0 + len.
- Twiddle index:
  - NTT: tw_idx = (1<<l) + group.
  - INTT: tw_idx = (128>>l) − 1 − group.
- Write-back:
  - rd_addr0/1 and rd_en pass through an L-deep shift register to become wr_addr0/1 and wr_en.
  - bf_sel passes through an RDLAT-deep shift register.
- start while busy is ignored.
- Reset mid-operation: FSM returns to IDLE; all counters and all shift-register valid bits clear; no further wr_en pulses.

## Timing
- Reset values: busy 0, done 0, rd_en 0, wr_en 0; all address, index and select outputs 0.
- If start is sampled at edge T0, the first rd_en is at cycle T0+1.
- Each layer takes 128 RUN cycles plus L DRAIN cycles. The full transform is 7·(128+L) = 980 cycles at the defaults, with done in the following cycle.
- A read issued at cycle c produces wr_en at cycle c+L.
- The last write of a layer lands in the final DRAIN cycle, so the first read of the next layer observes it.
- rd_en is low in DRAIN, DONE and IDLE.
- bf_sel[0] equals the latched mode throughout the transform.

## Structure
- Shared package:
  - N = 256, LAYERS = 7, AW, TWW
  - FSM state enum
  - mode encoding constants (NTT = 1, INTT = 0)
- One combinational sub-module, ntt_addr_calc: maps (l, b, mode) to (addr0, addr1, tw_idx).
- Delay lines reuse the existing k-cycle flop-chain primitive.

## Test plan
- NTT layer 0:
  - b = 0 → rd_addr (0, 128), tw_idx 1.
  - b = 127 → (127, 255), tw_idx 1.
  - Layer 1, b = 64 → (128, 192), tw_idx 3.
- INTT layer 0:
  - b = 0 → (0, 2), tw_idx 127.
  - b = 2 → (4, 6), tw_idx 126.
  - Layer 6, b = 0 → (0, 128), tw_idx 1.
- Latency: a read at cycle c gives wr_en at c+12 with identical addresses. bf_sel = 2'b01 (NTT) or 2'b00 (INTT) starting RDLAT after the first rd_en. Total cycles from start to done = 981.
- Coverage: over each layer, the union of rd_addr0/rd_addr1 covers 0..255 exactly once. No rd_en occurs while any wr_en from the previous layer is pending.
- Reset asserted in layer 3 of RUN: all outputs 0 immediately, FSM in IDLE, no wr_en afterwards. A new start then runs a clean 981-cycle transform.
- start pulsed while busy → ignored; mode change mid-transform → no effect; exactly one done pulse.
